// File: rtl/vdp9918_pkg.sv
// Shared types and constants for the VDP9918 VRAM arbiter.
//   VRAM_ADDR_W : VRAM address width (16 KB)
//   DATA_W      : VRAM data width
//   STARVE_W    : width of the CPU starvation counter
//   state_e     : arbiter state (IDLE, CMD, RDATA)
//   owner_e     : which requester owns the in-flight transaction
package vdp9918_pkg;

  localparam int unsigned VRAM_ADDR_W = 14;
  localparam int unsigned DATA_W      = 8;
  localparam int unsigned STARVE_W    = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    RDATA = 2'd2
  } state_e;

  typedef enum logic {
    OWN_CPU  = 1'b0,
    OWN_DISP = 1'b1
  } owner_e;

endpackage

// File: rtl/ip_vdp9918_cpu_req_latch.sv
// Holds the single pending CPU VRAM request (op, address, write data).
// Ports:
//   clk, n_reset         : clock, synchronous active-low reset
//   cpu_read, cpu_write  : one-cycle request strobes (write wins if both)
//   cpu_address          : request address, sampled with the strobe
//   cpu_write_data       : write data, sampled with cpu_write
//   clear                : CPU transaction finished, drop the pending request
//   pending              : a request is held (new strobes ignored while set)
//   pend_write           : held op is a write
//   pend_address         : held address
//   pend_data            : held write data (0 for reads)
module ip_vdp9918_cpu_req_latch
  import vdp9918_pkg::*;
#(
  parameter int unsigned ADDR_W = VRAM_ADDR_W
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_write_data,
  input  logic              clear,
  output logic              pending,
  output logic              pend_write,
  output logic [ADDR_W-1:0] pend_address,
  output logic [DATA_W-1:0] pend_data
);

  // Capture a new request only when nothing is held; write beats read.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      pending      <= 1'b0;
      pend_write   <= 1'b0;
      pend_address <= '0;
      pend_data    <= '0;
    end else if (clear) begin
      pending <= 1'b0;
    end else if (!pending && (cpu_read || cpu_write)) begin
      pending      <= 1'b1;
      pend_write   <= cpu_write;
      pend_address <= cpu_address;
      pend_data    <= cpu_write ? cpu_write_data : '0;
    end
  end

endmodule

// File: rtl/ip_vdp9918_vram_arbiter.sv
// Arbitrates the single VRAM port between CPU accesses and display fetches.
// One transaction outstanding at a time; display has priority, but after
// STARVE_LIMIT display grants with a CPU request waiting the CPU is served.
// Ports:
//   clk, n_reset                 : clock, synchronous active-low reset
//   enable                       : dot tick, grants only issue when high
//   cpu_read/cpu_write           : one-cycle CPU request strobes
//   cpu_address/cpu_write_data   : CPU request payload
//   cpu_busy                     : CPU request pending or in flight
//   cpu_read_ready/cpu_read_data : one-cycle CPU read result (data 0 otherwise)
//   disp_request/disp_address    : display fetch request, held until disp_ready
//   disp_ready/disp_data         : one-cycle display fetch result (data 0 otherwise)
//   mem_valid/mem_write/mem_address/mem_wdata : memory command, held until mem_ready
//   mem_ready                    : command accepted
//   mem_rdata_valid/mem_rdata    : memory read return
module ip_vdp9918_vram_arbiter
  import vdp9918_pkg::*;
#(
  parameter int unsigned ADDR_W       = VRAM_ADDR_W,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              enable,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_write_data,
  output logic              cpu_busy,
  output logic              cpu_read_ready,
  output logic [DATA_W-1:0] cpu_read_data,
  input  logic              disp_request,
  input  logic [ADDR_W-1:0] disp_address,
  output logic              disp_ready,
  output logic [DATA_W-1:0] disp_data,
  output logic              mem_valid,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rdata_valid,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  state_e              state;
  owner_e              owner;
  logic [STARVE_W-1:0] starve_cnt;

  logic                pending;
  logic                pend_write;
  logic [ADDR_W-1:0]   pend_address;
  logic [DATA_W-1:0]   pend_data;

  logic                clear_pending;
  logic                grant_ok;
  logic                pick_disp;
  logic                pick_cpu;

  ip_vdp9918_cpu_req_latch #(
    .ADDR_W (ADDR_W)
  ) u_cpu_req_latch (
    .clk            (clk),
    .n_reset        (n_reset),
    .cpu_read       (cpu_read),
    .cpu_write      (cpu_write),
    .cpu_address    (cpu_address),
    .cpu_write_data (cpu_write_data),
    .clear          (clear_pending),
    .pending        (pending),
    .pend_write     (pend_write),
    .pend_address   (pend_address),
    .pend_data      (pend_data)
  );

  assign cpu_busy = pending;

  // Grant selection and CPU completion. No grant in the disp_ready cycle:
  // the display requester is still holding the request it just got data for.
  always_comb begin
    grant_ok      = 1'b0;
    pick_disp     = 1'b0;
    pick_cpu      = 1'b0;
    clear_pending = 1'b0;

    grant_ok  = (state == IDLE) && enable && !disp_ready;
    pick_disp = grant_ok && disp_request && ((starve_cnt < LIMIT) || !pending);
    pick_cpu  = grant_ok && !pick_disp && pending;

    // Only the CPU issues writes, so a write acceptance always ends a CPU op.
    if ((state == CMD) && mem_ready && mem_write) begin
      clear_pending = 1'b1;
    end
    if ((state == RDATA) && mem_rdata_valid && (owner == OWN_CPU)) begin
      clear_pending = 1'b1;
    end
  end

  // Arbiter FSM with registered memory command and result outputs.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state          <= IDLE;
      owner          <= OWN_CPU;
      starve_cnt     <= '0;
      mem_valid      <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_wdata      <= '0;
      cpu_read_ready <= 1'b0;
      cpu_read_data  <= '0;
      disp_ready     <= 1'b0;
      disp_data      <= '0;
    end else begin
      cpu_read_ready <= 1'b0;
      cpu_read_data  <= '0;
      disp_ready     <= 1'b0;
      disp_data      <= '0;

      if (!pending) begin
        starve_cnt <= '0;
      end

      case (state)
        IDLE: begin
          if (pick_disp) begin
            state       <= CMD;
            owner       <= OWN_DISP;
            mem_valid   <= 1'b1;
            mem_write   <= 1'b0;
            mem_address <= disp_address;
            mem_wdata   <= '0;
            if (pending && (starve_cnt < LIMIT)) begin
              starve_cnt <= starve_cnt + STARVE_W'(1);
            end
          end else if (pick_cpu) begin
            state       <= CMD;
            owner       <= OWN_CPU;
            mem_valid   <= 1'b1;
            mem_write   <= pend_write;
            mem_address <= pend_address;
            mem_wdata   <= pend_data;
            starve_cnt  <= '0;
          end
        end

        CMD: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            state     <= mem_write ? IDLE : RDATA;
          end
        end

        RDATA: begin
          if (mem_rdata_valid) begin
            state <= IDLE;
            if (owner == OWN_DISP) begin
              disp_ready <= 1'b1;
              disp_data  <= mem_rdata;
            end else begin
              cpu_read_ready <= 1'b1;
              cpu_read_data  <= mem_rdata;
            end
          end
        end

        default: begin
          state     <= IDLE;
          mem_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
